seg7_scan_decoder: RTL

- Receive-side counterpart of the team's multiplexed 4-digit 7-segment driver.
- Snoops the active-low anode strobes and segment lines, waits for each digit window to settle, and decodes the segment pattern back to BCD.
- Reassembles a full 4-digit frame and presents it as a 16-bit BCD value with a one-cycle valid strobe.
- Used for display loopback checking on-board and as a scoreboard front end in system benches.

---
 rtl/seg7_scan_decoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 4-digit active-low 7-segment bus and rebuilds the BCD frame it shows.
// Optional SEG7_CHANGE_ONLY_EN: suppress value_valid for clean frames that repeat the current value.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [0:6]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        bad_seg,
  output logic        seq_err
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_SAT   = SCW'(SETTLE_CYCLES);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, COLLECT1 = 2'd1, COLLECT2 = 2'd2, COLLECT3 = 2'd3} state_e;

  // Returns {error, nibble}; undecodable patterns map to nibble F.
  function automatic logic [4:0] seg_decode(input logic [0:6] s);
    case (s)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      default:    return 5'h1F;
    endcase
  endfunction

  // Returns {valid, digit index}; only a single low anode is a valid strobe.
  function automatic logic [2:0] an_decode(input logic [3:0] a);
    case (a)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  logic [3:0]     an_p0_q, an_p1_q;
  logic [0:6]     seg_p0_q, seg_p1_q;
  logic [SCW-1:0] stab_q, stab_d;
  logic [TCW-1:0] to_q, to_d;
  state_e         state_q, state_d;
  logic [15:0]    buf_q, buf_d, value_q, value_d;
  logic           ferr_q, ferr_d, pend_q, pend_d;
  logic           valid_q, valid_d, bad_q, bad_d, seqerr_q, seqerr_d;

  logic           changed, fire, evt, dig_ok, nib_err;
  logic [1:0]     dig, exp_dig, exp_prev;
  logic [3:0]     nib;
  state_e         state_next;

  assign changed  = {an_p0_q, seg_p0_q} != {an_p1_q, seg_p1_q};
  assign fire     = (stab_q == SETTLE_LAST);
  assign {dig_ok, dig}  = an_decode(an_p1_q);
  assign {nib_err, nib} = seg_decode(seg_p1_q);
  assign evt      = fire && dig_ok;
  assign exp_dig  = state_q;
  assign exp_prev = exp_dig - 2'd1;

  always_comb begin
    state_next = HUNT;
    case (state_q)
      COLLECT1: state_next = COLLECT2;
      COLLECT2: state_next = COLLECT3;
      default:  state_next = HUNT;
    endcase
  end

  always_comb begin
    stab_d   = changed ? '0 : ((stab_q == SETTLE_SAT) ? stab_q : stab_q + SCW'(1));
    to_d     = (state_q == HUNT || evt) ? '0 : to_q + TCW'(1);
    state_d  = state_q;
    buf_d    = buf_q;
    ferr_d   = ferr_q;
    pend_d   = 1'b0;
    value_d  = value_q;
    valid_d  = 1'b0;
    bad_d    = 1'b0;
    seqerr_d = 1'b0;

    // Frame completion is reported one clock after the digit-3 sample.
    if (pend_q) begin
`ifdef SEG7_CHANGE_ONLY_EN
      if (ferr_q || buf_q != value_q) begin
        value_d = buf_q;
        valid_d = 1'b1;
        bad_d   = ferr_q;
      end
`else
      value_d = buf_q;
      valid_d = 1'b1;
      bad_d   = ferr_q;
`endif
    end

    if (state_q == HUNT) begin
      if (evt && dig == 2'd0) begin
        buf_d[3:0] = nib;
        ferr_d     = nib_err;
        state_d    = COLLECT1;
      end
    end else if (evt) begin
      if (dig == exp_dig) begin
        buf_d[{exp_dig, 2'b00} +: 4] = nib;
        ferr_d  = ferr_q | nib_err;
        state_d = state_next;
        pend_d  = (state_q == COLLECT3);
      end else if (dig == exp_prev) begin
        buf_d[{exp_prev, 2'b00} +: 4] = nib;
        ferr_d = ferr_q | nib_err;
      end else if (dig == 2'd0) begin
        seqerr_d   = 1'b1;
        buf_d[3:0] = nib;
        ferr_d     = nib_err;
        state_d    = COLLECT1;
      end else begin
        seqerr_d = 1'b1;
        state_d  = HUNT;
      end
    end else if (to_q == TIMEOUT_LAST) begin
      seqerr_d = 1'b1;
      state_d  = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_p0_q  <= 4'b1111;
      an_p1_q  <= 4'b1111;
      seg_p0_q <= 7'b1111111;
      seg_p1_q <= 7'b1111111;
      stab_q   <= '0;
      to_q     <= '0;
      state_q  <= HUNT;
      buf_q    <= '0;
      ferr_q   <= 1'b0;
      pend_q   <= 1'b0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      seqerr_q <= 1'b0;
    end else begin
      an_p0_q  <= an;
      an_p1_q  <= an_p0_q;
      seg_p0_q <= seg;
      seg_p1_q <= seg_p0_q;
      stab_q   <= stab_d;
      to_q     <= to_d;
      state_q  <= state_d;
      buf_q    <= buf_d;
      ferr_q   <= ferr_d;
      pend_q   <= pend_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
      seqerr_q <= seqerr_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign bad_seg     = bad_q;
  assign seq_err     = seqerr_q;

endmodule
